// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM encoding, frame geometry and scancode constants
// used by the receiver and the downstream per-key button machines.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_payload_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input ps2_payload_t p);
    return ^{p.data, p.parity};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Decoded-scancode bus from the PS/2 receiver to its consumers.
interface ps2_rx_if;
  import ps2_pkg::*;

  logic [7:0] ps2_out;
  logic       ps2_pulse;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (output ps2_out, ps2_pulse, parity_err, frame_err, busy);
  modport slave  (input  ps2_out, ps2_pulse, parity_err, frame_err, busy);

endinterface

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer followed by a stability filter for one raw PS/2 pin.
// The output only follows the pin after FILTER_LEN consecutive differing cycles.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Any agreement with the filtered value restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      dout <= 1'b1;
    end else if (sync2 == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILTER_LEN - 1)) begin
      cnt  <= '0;
      dout <= sync2;
    end else begin
      cnt <= CNT_W'(cnt + 1'b1);
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the raw pins, frames 11-bit words on ps2_clk
// falling edges and reports each byte as a good scancode, parity error or frame error.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  ps2_rx_if.master    rx
);

  localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

  logic clk_f;
  logic data_f;
  logic clk_f_d;
  logic fall_r;
  logic data_s;

  logic [1:0]       state,     state_nxt;
  ps2_payload_t     frame_q,   frame_nxt;
  logic [BIT_W-1:0] bit_cnt,   bit_nxt;
  logic [TO_W-1:0]  to_cnt,    to_nxt;
  logic [7:0]       out_q,     out_nxt;
  logic             pulse_q,   pulse_nxt;
  logic             perr_q,    perr_nxt;
  logic             ferr_q,    ferr_nxt;
  logic             busy_q,    busy_nxt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_clk),
    .dout  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ps2_data),
    .dout  (data_f)
  );

  // Registered falling edge with the data sample taken in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_f_d <= 1'b1;
      fall_r  <= 1'b0;
      data_s  <= 1'b1;
    end else begin
      clk_f_d <= clk_f;
      fall_r  <= clk_f_d & ~clk_f;
      data_s  <= data_f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      frame_q <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
      out_q   <= '0;
      pulse_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      frame_q <= frame_nxt;
      bit_cnt <= bit_nxt;
      to_cnt  <= to_nxt;
      out_q   <= out_nxt;
      pulse_q <= pulse_nxt;
      perr_q  <= perr_nxt;
      ferr_q  <= ferr_nxt;
      busy_q  <= busy_nxt;
    end
  end

  // Frame sequencing; a falling edge always takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_q;
    bit_nxt   = bit_cnt;
    out_nxt   = out_q;
    pulse_nxt = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    to_nxt    = (state == ST_IDLE) ? '0 : TO_W'(to_cnt + 1'b1);

    if (fall_r) begin
      to_nxt = '0;
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state_nxt = ST_DATA;
            bit_nxt   = '0;
          end
        end
        ST_DATA: begin
          frame_nxt.data[bit_cnt] = data_s;
          if (bit_cnt == BIT_W'(PS2_DATA_BITS - 1)) begin
            state_nxt = ST_PARITY;
          end else begin
            bit_nxt = BIT_W'(bit_cnt + 1'b1);
          end
        end
        ST_PARITY: begin
          frame_nxt.parity = data_s;
          state_nxt        = ST_STOP;
        end
        default: begin
          state_nxt = ST_IDLE;
          if (!data_s) begin
            ferr_nxt = 1'b1;
          end else if (!odd_parity_ok(frame_q)) begin
            perr_nxt = 1'b1;
          end else begin
            out_nxt   = frame_q.data;
            pulse_nxt = 1'b1;
          end
        end
      endcase
    end else if (state != ST_IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_nxt = ST_IDLE;
      frame_nxt = '0;
      bit_nxt   = '0;
      to_nxt    = '0;
      ferr_nxt  = 1'b1;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  assign rx.ps2_out    = out_q;
  assign rx.ps2_pulse  = pulse_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: a PS/2 device model drives frames, a strobe monitor logs events,
// and results are compared against a table and a byte-level frame model.
module tb_ps2_rx;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int HP = 40;
  localparam int K_PULSE = 1;
  localparam int K_PAR   = 2;
  localparam int K_FRM   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic ps2_clk;
  logic ps2_data;

  ps2_rx_if bus ();

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] out;
    int         cyc;
  } evt_t;

  typedef struct {
    logic [7:0] d;
    bit         pf;
    bit         sv;
    int         kind;
    logic [7:0] out;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  evt_t evq[$];
  bit   prev_any = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs every strobe, checks mutual exclusion and one-cycle width.
  always @(negedge clk) begin
    int   n;
    evt_t e;
    n = int'(bus.ps2_pulse) + int'(bus.parity_err) + int'(bus.frame_err);
    if (n != 0) begin
      tests++;
      if (n > 1) begin
        fails++;
        $display("FAIL strobe_onehot: %0d strobes high at cycle %0d, required 1", n, cyc);
      end
      tests++;
      if (prev_any) begin
        fails++;
        $display("FAIL strobe_width: strobe still high at cycle %0d, required one cycle", cyc);
      end
      e.kind = bus.ps2_pulse ? K_PULSE : (bus.parity_err ? K_PAR : K_FRM);
      e.out  = bus.ps2_out;
      e.cyc  = cyc;
      evq.push_back(e);
    end
    prev_any = (n != 0);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit pf, input bit sv);
    logic p;
    p = (~^d) ^ pf;
    return {sv, p, d, 1'b0};
  endfunction

  // Reference outcome of a complete frame, straight from the frame rules.
  function automatic int model_kind(input logic [10:0] f);
    if (!f[10])          return K_FRM;
    else if (!(^f[9:1])) return K_PAR;
    else                 return K_PULSE;
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit chk_busy);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HP / 2);
      if (chk_busy && i > 0) check("busy_in_frame", int'(bus.busy), 1);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cyc(HP);
      ps2_clk = 1'b1;
      wait_cyc(HP / 2);
    end
  endtask

  task automatic expect_evt(input string name, input int kind, input logic [7:0] out);
    evt_t e;
    if (evq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no strobe seen, required kind %0d out 0x%0h", name, kind, out);
    end else begin
      e = evq.pop_front();
      check({name, "_kind"}, e.kind, kind);
      check({name, "_out"}, int'(e.out), int'(out));
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_no_strobe"}, evq.size(), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
    evq.delete();
  endtask

  vec_t       tbl[6];
  logic [7:0] last_good;

  initial begin
    logic [10:0] f;
    logic [7:0]  d;
    bit          pf, sv;
    int          r, k, gap, waited;
    evt_t        e;

    tbl[0] = '{d: 8'h1C, pf: 1'b0, sv: 1'b1, kind: K_PULSE, out: 8'h1C};
    tbl[1] = '{d: 8'hF0, pf: 1'b0, sv: 1'b1, kind: K_PULSE, out: 8'hF0};
    tbl[2] = '{d: 8'h1C, pf: 1'b0, sv: 1'b1, kind: K_PULSE, out: 8'h1C};
    tbl[3] = '{d: 8'h29, pf: 1'b0, sv: 1'b1, kind: K_PULSE, out: 8'h29};
    tbl[4] = '{d: 8'h1C, pf: 1'b1, sv: 1'b1, kind: K_PAR,   out: 8'h29};
    tbl[5] = '{d: 8'h1C, pf: 1'b0, sv: 1'b0, kind: K_FRM,   out: 8'h29};

    rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    check("rst_out", int'(bus.ps2_out), 0);
    check("rst_pulse", int'(bus.ps2_pulse), 0);
    check("rst_perr", int'(bus.parity_err), 0);
    check("rst_ferr", int'(bus.frame_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // Table frames sent back-to-back; the first also checks busy through the frame.
    for (int i = 0; i < 6; i++) begin
      send_bits(mk_frame(tbl[i].d, tbl[i].pf, tbl[i].sv), 11, i == 0);
      expect_evt($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].out);
    end
    ps2_data = 1'b1;
    wait_cyc(50);
    check_quiet("tbl_end");
    last_good = 8'h29;

    // Randomized frames against the frame model.
    for (int i = 0; i < 30; i++) begin
      d  = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 9);
      pf = (r == 0);
      sv = (r != 1);
      f  = mk_frame(d, pf, sv);
      k  = model_kind(f);
      if (k == K_PULSE) last_good = d;
      send_bits(f, 11, 1'b0);
      expect_evt($sformatf("rnd%0d", i), k, last_good);
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
      if (gap > 0) begin
        ps2_data = 1'b1;
        wait_cyc(gap);
      end
    end
    ps2_data = 1'b1;
    wait_cyc(50);
    check_quiet("rnd_end");
    check("rnd_hold_out", int'(bus.ps2_out), int'(last_good));

    // Short glitch on idle ps2_clk must be ignored.
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    check_quiet("glitch");
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, 1'b0);
    expect_evt("after_glitch", K_PULSE, 8'h29);

    // Partial frame then silence: frame_err exactly TO cycles after the normal strobe point.
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 5, 1'b0);
    check("to_busy_wait", int'(bus.busy), 1);
    waited = 0;
    while (evq.size() == 0 && waited < TO + 300) begin
      wait_cyc(1);
      waited++;
    end
    if (evq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL timeout_evt: no frame_err within %0d cycles", waited);
    end else begin
      e = evq.pop_front();
      check("timeout_kind", e.kind, K_FRM);
      check("timeout_lat", e.cyc - last_fall_cyc, FL + 4 + TO);
      check("timeout_out", int'(e.out), 8'h29);
    end
    wait_cyc(5);
    check_quiet("after_timeout");
    send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
    expect_evt("post_to_5a", K_PULSE, 8'h5A);
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, 1'b0);
    expect_evt("post_to_29", K_PULSE, 8'h29);

    // Reset mid-frame: outputs clear at once, leftover bits produce nothing.
    f = mk_frame(8'hF0, 1'b0, 1'b1);
    send_bits(f, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", int'(bus.ps2_out), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_strobes", int'({bus.ps2_pulse, bus.parity_err, bus.frame_err}), 0);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    send_bits(f >> 5, 6, 1'b0);
    wait_cyc(40);
    check_quiet("after_mid_rst");
    check("after_mid_rst_out", int'(bus.ps2_out), 0);
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11, 1'b0);
    expect_evt("post_rst", K_PULSE, 8'h1C);
    wait_cyc(20);
    check_quiet("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
